// File: rtl/spi_mem_slave_if.sv
// SPI link between a serial host (master) and spi_mem_slave (slave).
interface spi_mem_slave_if;
  logic SS_n;
  logic MOSI;
  logic MISO;

  modport slave  (input SS_n, input MOSI, output MISO);
  modport master (output SS_n, output MOSI, input MISO);
endinterface

// File: rtl/spi_mem_slave.sv
// SPI-slave memory: 2-bit commands load write/read addresses or move one data word, MSB first.
// Define SPI_MEM_BURST_EN to auto-increment addresses and stream data words until SS_n rises.
module spi_mem_slave #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic           clk,
  input  logic           rst,
  spi_mem_slave_if.slave spi
);
  localparam int RXW = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
  localparam int CW  = $clog2(RXW);
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_CMD     = 3'd2;
  localparam logic [2:0] S_WR_ADDR = 3'd3;
  localparam logic [2:0] S_WR_DATA = 3'd4;
  localparam logic [2:0] S_RD_ADDR = 3'd5;
  localparam logic [2:0] S_RD_DATA = 3'd6;
  localparam logic [2:0] S_HOLD    = 3'd7;

  logic [2:0]            r_state;
  logic                  r_armed;
  logic                  r_cmd_hi;
  logic [CW-1:0]         r_cnt;
  logic [RXW-2:0]        r_rx;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0] r_mem [0:MEM_DEPTH-1];

  logic [RXW-1:0]        w_rx_next;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_last_addr;
  logic                  w_last_data;
  logic                  w_mem_we;

  function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < LP_DEPTH;
  endfunction

`ifdef SPI_MEM_BURST_EN
  localparam logic [ADDR_WIDTH:0] LP_LAST = (ADDR_WIDTH+1)'(MEM_DEPTH - 1);

  function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= LP_LAST) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  // The CMD edge loads the current word; mid-burst the following word is prefetched.
  assign w_rd_idx = (r_state == S_CMD) ? r_rd_addr : f_next_addr(r_rd_addr);
`else
  assign w_rd_idx = r_rd_addr;
`endif

  assign w_rx_next   = {r_rx, spi.MOSI};
  assign w_last_addr = (r_cnt == CW'(ADDR_WIDTH - 1));
  assign w_last_data = (r_cnt == CW'(DATA_WIDTH - 1));
  assign w_rd_word   = f_in_range(w_rd_idx) ? r_mem[w_rd_idx] : '0;
  assign w_mem_we    = (r_state == S_WR_DATA) && !spi.SS_n && w_last_data
                       && f_in_range(r_wr_addr);
  assign spi.MISO    = (r_state == S_RD_DATA) && r_tx[DATA_WIDTH-1];

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_wr_addr] <= w_rx_next[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_armed   <= 1'b0;
      r_cmd_hi  <= 1'b0;
      r_cnt     <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_wr_addr <= '0;
      r_rd_addr <= '0;
    end else if (spi.SS_n) begin
      // A frame may only begin after SS_n has been seen high since reset.
      r_state <= S_IDLE;
      r_armed <= 1'b1;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (r_armed) r_state <= S_START;
        S_START: begin
          r_cmd_hi <= spi.MOSI;
          r_state  <= S_CMD;
        end
        S_CMD: begin
          r_cnt <= '0;
          case ({r_cmd_hi, spi.MOSI})
            2'b00:   r_state <= S_WR_ADDR;
            2'b01:   r_state <= S_WR_DATA;
            2'b10:   r_state <= S_RD_ADDR;
            default: begin
              r_tx    <= w_rd_word;
              r_state <= S_RD_DATA;
            end
          endcase
        end
        S_WR_ADDR, S_RD_ADDR: begin
          r_rx <= w_rx_next[RXW-2:0];
          if (w_last_addr) begin
            if (r_state == S_WR_ADDR) r_wr_addr <= w_rx_next[ADDR_WIDTH-1:0];
            else                      r_rd_addr <= w_rx_next[ADDR_WIDTH-1:0];
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WR_DATA: begin
          r_rx <= w_rx_next[RXW-2:0];
          if (w_last_data) begin
`ifdef SPI_MEM_BURST_EN
            r_wr_addr <= f_next_addr(r_wr_addr);
            r_cnt     <= '0;
`else
            r_state   <= S_HOLD;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RD_DATA: begin
          if (w_last_data) begin
`ifdef SPI_MEM_BURST_EN
            r_rd_addr <= w_rd_idx;
            r_tx      <= w_rd_word;
            r_cnt     <= '0;
`else
            r_state   <= S_HOLD;
`endif
          end else begin
            r_tx  <= {r_tx[DATA_WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_HOLD;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_mem_slave.sv
// Directed bench for spi_mem_slave: host tasks queue expected read words, a negedge monitor checks them.
module tb_spi_mem_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ss = 1'b1;
  logic mosi = 1'b0;
  int   sel = 0;
  int   mode = 1;   // 0 ignore MISO, 1 MISO must be 0, 2 collect read data

  int n_total = 0;
  int n_pass  = 0;
  int zero_bad = 0;
  logic [7:0] exp_q [$];

  spi_mem_slave_if spi_a ();
  spi_mem_slave_if spi_b ();

  assign spi_a.SS_n = (sel == 0) ? ss : 1'b1;
  assign spi_b.SS_n = (sel == 1) ? ss : 1'b1;
  assign spi_a.MOSI = mosi;
  assign spi_b.MOSI = mosi;

  logic miso;
  assign miso = (sel == 1) ? spi_b.MISO : spi_a.MISO;

  spi_mem_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .spi(spi_a));
  spi_mem_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200)) dut200 (
    .clk(clk), .rst(rst), .spi(spi_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
      $display("ok   %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: one word per DATA_WIDTH collected bits, compared to the oldest queued expectation.
  logic [7:0] mon_word = 8'h00;
  int         mon_n = 0;
  always @(negedge clk) begin
    if (mode == 2) begin
      mon_word = {mon_word[6:0], miso};
      mon_n++;
      if (mon_n == 8) begin
        mon_n = 0;
        if (exp_q.size() == 0) chk("rd_unexpected_word", 32'(mon_word), 32'hFFFF_FFFF);
        else                   chk("rd_word", 32'(mon_word), 32'(exp_q.pop_front()));
      end
    end else begin
      mon_n = 0;
      if (mode == 1 && miso !== 1'b0) zero_bad++;
    end
  end

  task automatic e(input logic s, input logic m);
    ss   = s;
    mosi = m;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [1:0] cmd, input logic [31:0] bits, input int nbits, input int md);
    mode = 1;
    e(1'b0, 1'b0);
    e(1'b0, cmd[1]);
    e(1'b0, cmd[0]);
    mode = md;
    for (int i = nbits - 1; i >= 0; i--) e(1'b0, (md == 2) ? 1'b0 : bits[i]);
    mode = (md == 2) ? 0 : 1;
    e(1'b1, 1'b0);
    mode = 1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    frame(2'b00, 32'(a), 8, 1);
    frame(2'b01, 32'(d), 8, 1);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] d);
    frame(2'b10, 32'(a), 8, 1);
    exp_q.push_back(d);
    frame(2'b11, 32'h0, 8, 2);
  endtask

  logic [7:0] v0_exp, v255_exp, v254_exp;

  initial begin
    #12;
    chk("reset_miso_a", 32'(spi_a.MISO), 32'h0);
    chk("reset_miso_b", 32'(spi_b.MISO), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    e(1'b1, 1'b0);
    e(1'b1, 1'b0);

    // 100 single-word writes then reads of 100..199: data 11,22,...,253 then wraps to 11
    for (int i = 0; i < 100; i++) wr(8'(100 + i), 8'(11 * ((i % 23) + 1)));
    for (int i = 0; i < 100; i++) rd(8'(100 + i), 8'(11 * ((i % 23) + 1)));

    // Aborted write: SS_n rises after 5 of 8 bits of 0xA5
    wr(8'd7, 8'h3C);
    rd(8'd7, 8'h3C);
    frame(2'b00, 32'd7, 8, 1);
    frame(2'b01, 32'h14, 5, 1);
    rd(8'd7, 8'h3C);

    // Three-word frame at 254
    wr(8'd255, 8'hEE);
    wr(8'd0, 8'hDD);
    frame(2'b00, 32'd254, 8, 1);
    frame(2'b01, 32'h010203, 24, 1);
`ifdef SPI_MEM_BURST_EN
    v254_exp = 8'h01; v255_exp = 8'h02; v0_exp = 8'h03;
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
`else
    v254_exp = 8'h01; v255_exp = 8'hEE; v0_exp = 8'hDD;
    exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
`endif
    frame(2'b10, 32'd254, 8, 1);
    frame(2'b11, 32'h0, 24, 2);
    rd(8'd254, v254_exp);
    rd(8'd255, v255_exp);
    rd(8'd0, v0_exp);

    // Depth-200 instance: out-of-range write dropped, read returns zero
    e(1'b1, 1'b0);
    sel = 1;
    e(1'b1, 1'b0);
    wr(8'd5, 8'h5A);
    wr(8'd30, 8'h30);
    wr(8'd230, 8'h77);
    rd(8'd230, 8'h00);
    rd(8'd5, 8'h5A);
    rd(8'd30, 8'h30);
    sel = 0;
    e(1'b1, 1'b0);

    // Reset during payload bit 4 of a read from 150 (value 55)
    frame(2'b10, 32'd150, 8, 1);
    e(1'b0, 1'b0);
    e(1'b0, 1'b1);
    e(1'b0, 1'b1);
    mode = 0;
    for (int i = 0; i < 4; i++) e(1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 chk("miso_on_rst", 32'(spi_a.MISO), 32'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    // SS_n still low: this write-shaped sequence must not start a frame
    mode = 1;
    e(1'b0, 1'b0);
    e(1'b0, 1'b0);
    e(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) e(1'b0, 1'b1);
    e(1'b1, 1'b0);
    rd(8'd150, 8'd55);
    rd(8'd0, v0_exp);
    e(1'b1, 1'b0);

    chk("miso_zero_outside_rd", 32'(zero_bad), 32'h0);
    chk("rd_queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
